csr_file: RTL and testbench

Machine-mode CSR register file for the RV32IM core. It sits directly around the CSR update stage:
- Supplies the current CSR value for the addressed register to that stage.
- Commits the new value that stage computes.
- Owns the cycle/instret counters and trap entry/return (mret) state.
- Drives the trap vector and mepc to the fetch/PC logic.

---
 rtl/csr_file_if.sv | 29 ++
 rtl/csr_file.sv | 135 +++++++++++++
 tb/tb_csr_file.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_file_if.sv
// Bus between the CSR update stage / PC logic and the machine-mode CSR file.
// The master side drives the CSR access and trap/mret events; the slave side is the CSR file.
interface csr_file_if;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_rd_data_o;
    logic        csr_wr_en_i;
    logic [31:0] csr_wr_data_i;
    logic        illegal_o;
    logic        instret_i;
    logic        trap_i;
    logic [31:0] trap_cause_i;
    logic [31:0] trap_pc_i;
    logic        mret_i;
    logic [31:0] trap_vector_o;
    logic [31:0] mepc_o;
    logic        mie_bit_o;

    modport master (
        output csr_addr_i, csr_wr_en_i, csr_wr_data_i, instret_i,
               trap_i, trap_cause_i, trap_pc_i, mret_i,
        input  csr_rd_data_o, illegal_o, trap_vector_o, mepc_o, mie_bit_o
    );

    modport slave (
        input  csr_addr_i, csr_wr_en_i, csr_wr_data_i, instret_i,
               trap_i, trap_cause_i, trap_pc_i, mret_i,
        output csr_rd_data_o, illegal_o, trap_vector_o, mepc_o, mie_bit_o
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file for an RV32IM hart: status, trap CSRs, 64-bit cycle/instret
// counters, trap entry/mret sequencing and trap vector generation.
module csr_file #(
    parameter logic [31:0] HART_ID     = 32'h0000_0000,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_1100
) (
    input  logic      clk,
    input  logic      reset,
    csr_file_if.slave bus
);
    logic        r_mie;
    logic        r_mpie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    logic [31:0] w_mstatus;
    logic [31:0] w_rd_data;
    logic        w_addr_valid;
    logic        w_illegal;
    logic        w_wr_ok;
    logic [31:0] w_base;
    logic [31:0] w_trap_vector;

    assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};

    // Read mux and address decode
    always_comb begin
        w_rd_data    = 32'd0;
        w_addr_valid = 1'b1;
        case (bus.csr_addr_i)
            12'h300:          w_rd_data = w_mstatus;
            12'h301:          w_rd_data = MISA_VALUE;
            12'h305:          w_rd_data = r_mtvec;
            12'h340:          w_rd_data = r_mscratch;
            12'h341:          w_rd_data = r_mepc;
            12'h342:          w_rd_data = r_mcause;
            12'hB00, 12'hC00: w_rd_data = r_mcycle[31:0];
            12'hB80, 12'hC80: w_rd_data = r_mcycle[63:32];
            12'hB02, 12'hC02: w_rd_data = r_minstret[31:0];
            12'hB82, 12'hC82: w_rd_data = r_minstret[63:32];
            12'hF14:          w_rd_data = HART_ID;
            default: begin
                w_rd_data    = 32'd0;
                w_addr_valid = 1'b0;
            end
        endcase
    end

    assign w_illegal = ~w_addr_valid | (bus.csr_wr_en_i & (bus.csr_addr_i[11:10] == 2'b11));
    // Trap and mret take the edge; a coincident CSR write is dropped
    assign w_wr_ok   = bus.csr_wr_en_i & ~w_illegal & ~bus.trap_i & ~bus.mret_i;

    // Interrupt causes jump to base + 4*cause only in vectored mode
    always_comb begin
        w_base = {r_mtvec[31:2], 2'b00};
        if (r_mtvec[0] && bus.trap_cause_i[31]) begin
            w_trap_vector = w_base + {25'd0, bus.trap_cause_i[4:0], 2'b00};
        end else begin
            w_trap_vector = w_base;
        end
    end

    // Trap entry, mret and CSR writes to status/trap registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= 32'd0;
            r_mepc     <= 32'd0;
            r_mcause   <= 32'd0;
        end else if (bus.trap_i) begin
            r_mepc   <= bus.trap_pc_i & 32'hFFFF_FFFC;
            r_mcause <= bus.trap_cause_i;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (bus.mret_i) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_wr_ok) begin
            case (bus.csr_addr_i)
                12'h300: begin
                    r_mie  <= bus.csr_wr_data_i[3];
                    r_mpie <= bus.csr_wr_data_i[7];
                end
                12'h305: r_mtvec    <= bus.csr_wr_data_i & 32'hFFFF_FFFD;
                12'h340: r_mscratch <= bus.csr_wr_data_i;
                12'h341: r_mepc     <= bus.csr_wr_data_i & 32'hFFFF_FFFC;
                12'h342: r_mcause   <= bus.csr_wr_data_i;
                default: r_mie      <= r_mie;
            endcase
        end else begin
            r_mie <= r_mie;
        end
    end

    // mcycle: free-running, a half write replaces that half and skips this cycle's increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcycle <= 64'd0;
        end else if (w_wr_ok && bus.csr_addr_i == 12'hB00) begin
            r_mcycle[31:0] <= bus.csr_wr_data_i;
        end else if (w_wr_ok && bus.csr_addr_i == 12'hB80) begin
            r_mcycle[63:32] <= bus.csr_wr_data_i;
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end

    // minstret: counts retirements, same write override as mcycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_minstret <= 64'd0;
        end else if (w_wr_ok && bus.csr_addr_i == 12'hB02) begin
            r_minstret[31:0] <= bus.csr_wr_data_i;
        end else if (w_wr_ok && bus.csr_addr_i == 12'hB82) begin
            r_minstret[63:32] <= bus.csr_wr_data_i;
        end else if (bus.instret_i) begin
            r_minstret <= r_minstret + 64'd1;
        end else begin
            r_minstret <= r_minstret;
        end
    end

    assign bus.csr_rd_data_o = w_rd_data;
    assign bus.illegal_o     = w_illegal;
    assign bus.trap_vector_o = w_trap_vector;
    assign bus.mepc_o        = r_mepc;
    assign bus.mie_bit_o     = r_mie;
endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: table of write/readback vectors plus hand-written
// sequences for reset, counter carry, retire counting, trap, mret and reset-during-trap.
module tb_csr_file;
    logic clk;
    logic reset;

    csr_file_if bus ();

    csr_file #(
        .HART_ID    (32'h0000_0000),
        .MTVEC_RESET(32'h0000_0000),
        .MISA_VALUE (32'h4000_1100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        string       nm;
        logic [11:0] wa;
        logic [31:0] wd;
        logic        will;
        logic [11:0] ra;
        logic [31:0] rexp;
        logic        rill;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vt[9];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic sb_push(input string nm, input logic [31:0] exp);
        sb_t e;
        e.nm  = nm;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_cmp(input logic [31:0] act);
        sb_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL sb_underflow got=%h", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.exp) begin
                n_errors++;
                $display("FAIL %s got=%h expected=%h", e.nm, act, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input string nm, input logic [31:0] exp);
        sb_push(nm, exp);
        bus.csr_wr_en_i = 1'b0;
        bus.csr_addr_i  = a;
        #1;
        sb_cmp(bus.csr_rd_data_o);
    endtask

    task automatic chk_ill(input string nm, input logic exp);
        sb_push(nm, {31'd0, exp});
        #1;
        sb_cmp({31'd0, bus.illegal_o});
    endtask

    task automatic chk_out(input string nm, input logic [31:0] exp, input int sel);
        sb_push(nm, exp);
        #1;
        case (sel)
            0:       sb_cmp(bus.mepc_o);
            1:       sb_cmp({31'd0, bus.mie_bit_o});
            default: sb_cmp(bus.trap_vector_o);
        endcase
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.csr_addr_i    = a;
        bus.csr_wr_data_i = d;
        bus.csr_wr_en_i   = 1'b1;
        step();
        bus.csr_wr_en_i   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{"mscratch_rw",   12'h340, 32'hDEAD_BEEF, 1'b0, 12'h340, 32'hDEAD_BEEF, 1'b0};
        vt[1] = '{"mepc_align",    12'h341, 32'h0000_1237, 1'b0, 12'h341, 32'h0000_1234, 1'b0};
        vt[2] = '{"mtvec_bit1",    12'h305, 32'h8000_0003, 1'b0, 12'h305, 32'h8000_0001, 1'b0};
        vt[3] = '{"mcause_rw",     12'h342, 32'h8000_000B, 1'b0, 12'h342, 32'h8000_000B, 1'b0};
        vt[4] = '{"mstatus_ones",  12'h300, 32'hFFFF_FFFF, 1'b0, 12'h300, 32'h0000_1888, 1'b0};
        vt[5] = '{"mstatus_zero",  12'h300, 32'h0000_0000, 1'b0, 12'h300, 32'h0000_1800, 1'b0};
        vt[6] = '{"misa_warl",     12'h301, 32'h0000_0000, 1'b0, 12'h301, 32'h4000_1100, 1'b0};
        vt[7] = '{"mhartid_ro",    12'hF14, 32'h0000_0005, 1'b1, 12'hF14, 32'h0000_0000, 1'b0};
        vt[8] = '{"unimpl_7c0",    12'h7C0, 32'h1234_5678, 1'b1, 12'h7C0, 32'h0000_0000, 1'b1};

        reset              = 1'b1;
        bus.csr_addr_i     = 12'h000;
        bus.csr_wr_en_i    = 1'b0;
        bus.csr_wr_data_i  = 32'd0;
        bus.instret_i      = 1'b0;
        bus.trap_i         = 1'b0;
        bus.trap_cause_i   = 32'd0;
        bus.trap_pc_i      = 32'd0;
        bus.mret_i         = 1'b0;
        step();
        step();
        reset = 1'b0;
        rd(12'hB00, "mcycle_after_reset", 32'd0);
        step();
        step();
        step();
        // reset mid-run clears counters immediately
        reset = 1'b1;
        rd(12'hB00, "mcycle_async_reset", 32'd0);
        step();
        reset = 1'b0;
        rd(12'hB00, "mcycle_0", 32'd0);
        rd(12'h301, "misa", 32'h4000_1100);
        rd(12'hF14, "mhartid", 32'h0000_0000);
        rd(12'h7C0, "unimpl_data", 32'd0);
        chk_ill("unimpl_ill", 1'b1);
        step();
        rd(12'hB00, "mcycle_1", 32'd1);
        step();
        rd(12'hB00, "mcycle_2", 32'd2);
        step();
        rd(12'hB00, "mcycle_3", 32'd3);
        chk_ill("mcycle_ill", 1'b0);

        for (int i = 0; i < 9; i++) begin
            bus.csr_addr_i    = vt[i].wa;
            bus.csr_wr_data_i = vt[i].wd;
            bus.csr_wr_en_i   = 1'b1;
            chk_ill({vt[i].nm, "_wr_ill"}, vt[i].will);
            step();
            rd(vt[i].ra, vt[i].nm, vt[i].rexp);
            chk_ill({vt[i].nm, "_rd_ill"}, vt[i].rill);
            step();
        end

        begin
            logic [31:0] v;
            bus.csr_addr_i = 12'hB00;
            #1;
            v = bus.csr_rd_data_o;
            bus.csr_addr_i    = 12'hC00;
            bus.csr_wr_data_i = 32'h0000_0055;
            bus.csr_wr_en_i   = 1'b1;
            chk_ill("cycle_wr_ill", 1'b1);
            step();
            rd(12'hB00, "cycle_wr_suppressed", v + 32'd1);
            rd(12'hC00, "cycle_alias", v + 32'd1);
        end

        wr(12'hB00, 32'hFFFF_FFFE);
        wr(12'hB80, 32'h0000_0000);
        rd(12'hB00, "carry_lo_held", 32'hFFFF_FFFE);
        step();
        rd(12'hB00, "carry_lo_max", 32'hFFFF_FFFF);
        rd(12'hB80, "carry_hi_0", 32'h0000_0000);
        step();
        rd(12'hB00, "carry_lo_wrap", 32'h0000_0000);
        rd(12'hB80, "carry_hi_1", 32'h0000_0001);
        rd(12'hC80, "carry_cycleh", 32'h0000_0001);

        wr(12'hB02, 32'd0);
        wr(12'hB82, 32'd0);
        bus.instret_i = 1'b1;
        for (int k = 0; k < 5; k++) step();
        bus.instret_i = 1'b0;
        rd(12'hB02, "minstret_5", 32'd5);
        rd(12'hC02, "instret_alias", 32'd5);
        step();
        rd(12'hB02, "minstret_idle", 32'd5);
        bus.instret_i = 1'b1;
        wr(12'hB02, 32'h0000_0100);
        bus.instret_i = 1'b0;
        rd(12'hB02, "minstret_wr_wins", 32'h0000_0100);
        rd(12'hB82, "minstreth", 32'd0);

        wr(12'h300, 32'h0000_0008);
        wr(12'h305, 32'h0000_0201);
        bus.trap_cause_i = 32'h0000_0007;
        chk_out("vec_exception", 32'h0000_0200, 2);
        bus.trap_cause_i = 32'h8000_0007;
        chk_out("vec_interrupt", 32'h0000_021C, 2);
        bus.trap_pc_i     = 32'h0000_0100;
        bus.trap_i        = 1'b1;
        bus.csr_addr_i    = 12'h340;
        bus.csr_wr_data_i = 32'h0BAD_F00D;
        bus.csr_wr_en_i   = 1'b1;
        step();
        bus.trap_i      = 1'b0;
        bus.csr_wr_en_i = 1'b0;
        chk_out("trap_mepc_o", 32'h0000_0100, 0);
        chk_out("trap_mie_o", 32'd0, 1);
        rd(12'h342, "trap_mcause", 32'h8000_0007);
        rd(12'h300, "trap_mstatus", 32'h0000_1880);
        rd(12'h340, "trap_drops_write", 32'hDEAD_BEEF);

        bus.mret_i        = 1'b1;
        bus.csr_addr_i    = 12'h340;
        bus.csr_wr_data_i = 32'h0000_1111;
        bus.csr_wr_en_i   = 1'b1;
        step();
        bus.mret_i      = 1'b0;
        bus.csr_wr_en_i = 1'b0;
        chk_out("mret_mie_o", 32'd1, 1);
        rd(12'h300, "mret_mstatus", 32'h0000_1888);
        rd(12'h340, "mret_drops_write", 32'hDEAD_BEEF);
        step();

        bus.trap_pc_i    = 32'h0000_0400;
        bus.trap_cause_i = 32'h0000_0005;
        bus.trap_i       = 1'b1;
        reset            = 1'b1;
        chk_out("rst_trap_mepc", 32'd0, 0);
        chk_out("rst_trap_mie", 32'd0, 1);
        rd(12'h305, "rst_trap_mtvec", 32'd0);
        step();
        chk_out("rst_edge_mepc", 32'd0, 0);
        rd(12'h342, "rst_edge_mcause", 32'd0);
        reset       = 1'b0;
        bus.trap_i  = 1'b0;
        step();
        chk_out("post_rst_mepc", 32'd0, 0);
        rd(12'h300, "post_rst_mstatus", 32'h0000_1800);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_leftover got=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
